// File: rtl/dm_sync.sv
// dm_sync: synchronous-read byte-enable data memory with post-reset clear, AdEL/AdES/RI detection and store trace.
module dm_sync #(
  parameter int DEPTH = 3072
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [3:0]  req_op_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  input  logic [31:0] req_pc_i,
  output logic        resp_valid_o,
  output logic [31:0] resp_data_o,
  output logic        resp_exc_o,
  output logic [4:0]  resp_exccode_o,
  output logic        trace_valid_o,
  output logic [31:0] trace_pc_o,
  output logic [31:0] trace_addr_o,
  output logic [31:0] trace_data_o,
  output logic        busy_o
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [31:0] SPAN = 32'(DEPTH * 4);

  typedef enum logic {CLEAR, IDLE} state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   clr_q, clr_d;
  logic [31:0]        mem [DEPTH];
  logic [31:0]        rd_q, wl, wl_q, pc_q, addr_q, ld, mg;
  logic [3:0]         op_q, be, be_q;
  logic [1:0]         lane_q;
  logic [4:0]         code, code_q;
  logic [IDX_W-1:0]   idx;
  logic               acc, st, mis, oor, we, valid_q, tv_q;
  logic [15:0]        half;
  logic [7:0]         byt;

  always_comb begin
    state_d = state_q;
    clr_d = clr_q;
    if (state_q == CLEAR) begin
      clr_d = clr_q + 1'b1;
      if (clr_q == IDX_W'(DEPTH - 1)) state_d = IDLE;
    end
  end

  assign req_ready_o = state_q == IDLE;
  assign busy_o = state_q == CLEAR;
  assign acc = req_valid_i && req_ready_o;
  assign st = req_op_i < 4'd3;
  assign mis = (req_op_i == 4'd0 || req_op_i == 4'd3) ? |req_addr_i[1:0] :
               (req_op_i == 4'd1 || req_op_i == 4'd4 || req_op_i == 4'd6) ? req_addr_i[0] : 1'b0;
  assign oor = req_addr_i >= SPAN;
  assign code = req_op_i[3] ? 5'd10 : (mis || oor) ? (st ? 5'd5 : 5'd4) : 5'd0;
  assign be = !st ? 4'h0 : req_op_i == 4'd0 ? 4'hf :
              req_op_i == 4'd1 ? (req_addr_i[1] ? 4'hc : 4'h3) : 4'b0001 << req_addr_i[1:0];
  // Store data is replicated across lanes so the byte enables alone pick the target bytes.
  assign wl = req_op_i == 4'd0 ? req_wdata_i : req_op_i == 4'd1 ? {2{req_wdata_i[15:0]}} : {4{req_wdata_i[7:0]}};
  assign we = acc && st && code == 5'd0;
  assign idx = req_addr_i[IDX_W+1:2];

  always_ff @(posedge clk) begin
    if (state_q == CLEAR && !reset) mem[clr_q] <= '0;
    else if (we)
      for (int b = 0; b < 4; b++)
        if (be[b]) mem[idx][8*b +: 8] <= wl[8*b +: 8];
    rd_q <= mem[idx];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= CLEAR;
      clr_q <= '0;
      valid_q <= 1'b0;
      tv_q <= 1'b0;
      op_q <= '0;
      lane_q <= '0;
      code_q <= '0;
      pc_q <= '0;
      addr_q <= '0;
      wl_q <= '0;
      be_q <= '0;
    end else begin
      state_q <= state_d;
      clr_q <= clr_d;
      valid_q <= acc;
      tv_q <= we;
      if (acc) begin
        op_q <= req_op_i;
        lane_q <= req_addr_i[1:0];
        code_q <= code;
        pc_q <= req_pc_i;
        addr_q <= req_addr_i;
        wl_q <= wl;
        be_q <= be;
      end
    end
  end

  // rd_q holds the pre-store word for stores, so the traced word is merged here.
  always_comb begin
    mg = rd_q;
    for (int b = 0; b < 4; b++)
      if (be_q[b]) mg[8*b +: 8] = wl_q[8*b +: 8];
  end

  assign half = lane_q[1] ? rd_q[31:16] : rd_q[15:0];
  assign byt = 8'(rd_q >> {lane_q, 3'b000});
  assign ld = op_q == 4'd3 ? rd_q : op_q == 4'd4 ? {{16{half[15]}}, half} :
              op_q == 4'd5 ? {{24{byt[7]}}, byt} : op_q == 4'd6 ? {16'h0, half} :
              op_q == 4'd7 ? {24'h0, byt} : 32'h0;

  assign resp_valid_o = valid_q;
  assign resp_exc_o = valid_q && code_q != 5'd0;
  assign resp_exccode_o = valid_q ? code_q : 5'd0;
  assign resp_data_o = (valid_q && code_q == 5'd0) ? ld : 32'h0;
  assign trace_valid_o = tv_q;
  assign trace_pc_o = tv_q ? pc_q : 32'h0;
  assign trace_addr_o = tv_q ? addr_q : 32'h0;
  assign trace_data_o = tv_q ? mg : 32'h0;
endmodule
